uart_baud_lock: RTL and testbench

//  Far-end autobaud partner for the fixed-rate uart: measures the host's bit period from a 0x55 sync

---
 rtl/uart_baud_lock.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_baud_lock.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_lock.sv
// Autobaud partner: measures the bit period of a 0x55 sync on rx, acks 0x55 on tx at that rate, then locks.
// Latency: rx edges seen 2 clk late (sync flops), divisor ready 1 clk after the stop edge, ack start 1 clk later.
// Backpressure: none; rx is free-running and relock is accepted in any state.
module uart_baud_lock #(
  parameter logic [19:0] MIN_BAUD  = 20'd8,
  parameter logic [22:0] MAX_COUNT = 23'h7FFFFF
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        rx,
  input  logic        relock,
  output logic        tx,
  output logic [19:0] baud,
  output logic        locked,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_WAIT_START,
    S_MEASURE,
    S_WAIT_STOP,
    S_CALC,
    S_ACK,
    S_LOCKED
  } state_t;

  // Ack frame, index 0 goes out first: start, 0x55 LSB-first, stop.
  localparam logic [9:0]  ACK_FRAME = {1'b1, 8'h55, 1'b0};
  // Falling edges of 0x55 are two bit periods apart, so anything shorter than
  // two minimum bit periods cannot be part of a legal sync.
  localparam logic [23:0] MIN_IVL   = {3'b000, MIN_BAUD, 1'b0};

  state_t      state, state_n;
  logic        rx_m, rx_s, rx_d;
  logic        fall, rise;
  logic [3:0]  idle_cnt, idle_n;
  logic [22:0] tot, tot_n, tot_inc;
  logic [22:0] ivl, ivl_n, ivl_inc;
  logic [23:0] ivl_p1;
  logic [2:0]  nfall, nfall_n;
  logic [22:3] meas, meas_n;
  logic [19:0] div;
  logic [19:0] ack_clk, ack_clk_n;
  logic [3:0]  ack_bit, ack_bit_n;
  logic        tx_n, locked_n, err_n;
  logic [19:0] baud_n;

  // Two-flop synchroniser plus one delay stage for edge detection on rx_s.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall    = rx_d & ~rx_s;
  assign rise    = ~rx_d & rx_s;
  assign tot_inc = (tot == MAX_COUNT) ? tot : tot + 23'd1;
  assign ivl_inc = (ivl == MAX_COUNT) ? ivl : ivl + 23'd1;
  assign ivl_p1  = {1'b0, ivl} + 24'd1;
  // meas holds 8 bit periods; divide by 8 and convert to the BAUD+1 convention.
  assign div     = meas[22:3] - 20'd1;
  assign busy    = !((state == S_WAIT_IDLE) || (state == S_WAIT_START) || (state == S_LOCKED));

  // Next-state and datapath decisions for the whole measure / ack sequence.
  always_comb begin
    state_n   = state;
    idle_n    = idle_cnt;
    tot_n     = tot;
    ivl_n     = ivl;
    nfall_n   = nfall;
    meas_n    = meas;
    ack_clk_n = ack_clk;
    ack_bit_n = ack_bit;
    tx_n      = tx;
    baud_n    = baud;
    locked_n  = locked;
    err_n     = 1'b0;

    case (state)
      S_WAIT_IDLE: begin
        // Require a quiet line so we never start measuring mid-byte.
        tx_n     = 1'b1;
        locked_n = 1'b0;
        if (!rx_s) begin
          idle_n = 4'd0;
        end else if (idle_cnt == 4'd15) begin
          idle_n  = 4'd0;
          state_n = S_WAIT_START;
        end else begin
          idle_n = idle_cnt + 4'd1;
        end
      end

      S_WAIT_START: begin
        if (fall) begin
          state_n = S_MEASURE;
          tot_n   = 23'd0;
          ivl_n   = 23'd0;
          nfall_n = 3'd1;
        end
      end

      S_MEASURE: begin
        tot_n = tot_inc;
        ivl_n = ivl_inc;
        if (ivl == MAX_COUNT) begin
          err_n   = 1'b1;
          state_n = S_WAIT_IDLE;
        end else if (fall) begin
          if (ivl_p1 < MIN_IVL) begin
            err_n   = 1'b1;
            state_n = S_WAIT_IDLE;
          end else begin
            ivl_n   = 23'd0;
            nfall_n = nfall + 3'd1;
            if (nfall == 3'd4) begin
              state_n = S_WAIT_STOP;
              meas_n  = tot_inc[22:3];
            end
          end
        end
      end

      S_WAIT_STOP: begin
        ivl_n = ivl_inc;
        if (ivl == MAX_COUNT) begin
          err_n   = 1'b1;
          state_n = S_WAIT_IDLE;
        end else if (rise) begin
          state_n = S_CALC;
        end
      end

      S_CALC: begin
        if (meas[22] || (div < MIN_BAUD)) begin
          err_n   = 1'b1;
          state_n = S_WAIT_IDLE;
        end else begin
          baud_n    = div;
          state_n   = S_ACK;
          ack_clk_n = 20'd0;
          ack_bit_n = 4'd0;
          tx_n      = ACK_FRAME[0];
        end
      end

      S_ACK: begin
        if (ack_clk == baud) begin
          ack_clk_n = 20'd0;
          if (ack_bit == 4'd9) begin
            state_n  = S_LOCKED;
            locked_n = 1'b1;
            tx_n     = 1'b1;
          end else begin
            ack_bit_n = ack_bit + 4'd1;
            tx_n      = ACK_FRAME[ack_bit_n];
          end
        end else begin
          ack_clk_n = ack_clk + 20'd1;
        end
      end

      S_LOCKED: begin
        tx_n = 1'b1;
      end

      default: begin
        state_n = S_WAIT_IDLE;
      end
    endcase

    // relock overrides everything, including a pending error.
    if (relock) begin
      state_n  = S_WAIT_IDLE;
      idle_n   = 4'd0;
      tx_n     = 1'b1;
      locked_n = 1'b0;
      err_n    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= S_WAIT_IDLE;
      idle_cnt <= 4'd0;
      tot      <= 23'd0;
      ivl      <= 23'd0;
      nfall    <= 3'd0;
      meas     <= 20'd0;
      ack_clk  <= 20'd0;
      ack_bit  <= 4'd0;
      tx       <= 1'b1;
      baud     <= 20'd0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_n;
      tot      <= tot_n;
      ivl      <= ivl_n;
      nfall    <= nfall_n;
      meas     <= meas_n;
      ack_clk  <= ack_clk_n;
      ack_bit  <= ack_bit_n;
      tx       <= tx_n;
      baud     <= baud_n;
      locked   <= locked_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_baud_lock.sv
// Bench for uart_baud_lock: table of sync rates plus hand-written corner sequences.
// Stimulus driven on negedges, outputs sampled on negedges.
// Expected divisors and timings are computed by hand from the bit periods used.
module tb_uart_baud_lock;

  localparam logic [19:0] MINB = 20'd8;
  localparam logic [22:0] MAXC = 23'd2000;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        rx = 1'b1;
  logic        relock = 1'b0;
  logic        tx;
  logic [19:0] baud;
  logic        locked;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int err_cnt = 0;
  logic err_q = 1'b0;

  uart_baud_lock #(.MIN_BAUD(MINB), .MAX_COUNT(MAXC)) dut (
    .clk    (clk),
    .nRst   (nRst),
    .rx     (rx),
    .relock (relock),
    .tx     (tx),
    .baud   (baud),
    .locked (locked),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          p;
    logic [19:0] exp_baud;
    logic        exp_lock;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // err must be a single-cycle pulse; also count pulses for the sequences.
  always @(negedge clk) begin
    if (err === 1'b1) begin
      err_cnt++;
      check("err_single_cycle", err_q, 0);
    end
    err_q = err;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sync(input int p);
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = fr[i];
      if (i == 9) stop_cyc = cyc;
      repeat (p - 1) @(negedge clk);
    end
  endtask

  task automatic wait_tx_low(input int bound);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < bound) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic watch_lock(input int p);
    int   len;
    logic lvl;
    wait_tx_low(14 * p + 100);
    check("ack_start_seen", tx, 0);
    if (tx === 1'b0) begin
      check("ack_start_latency", cyc - stop_cyc, 4);
      for (int r = 0; r < 9; r++) begin
        lvl = tx;
        check("ack_bit_level", lvl, r % 2);
        len = 0;
        while (tx === lvl && len < 2 * p + 10) begin
          @(negedge clk);
          len++;
        end
        check("ack_bit_len", len, p);
      end
      len = 0;
      while (locked !== 1'b1 && len < 2 * p + 10) begin
        @(negedge clk);
        len++;
      end
      check("lock_after_stop", len, p);
      check("lock_tx_idle", tx, 1);
    end
  endtask

  task automatic watch_err(input int p);
    int lows;
    lows = 0;
    repeat (12 * p + 60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("err_tx_stays_high", lows, 0);
  endtask

  task automatic do_relock(input logic [19:0] held);
    @(negedge clk);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    check("relock_drops_lock", locked, 0);
    check("relock_baud_held", baud, held);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_baud"}, baud, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int e0;
    int t;
    int bad;

    vecs[0] = '{p: 216, exp_baud: 20'd215, exp_lock: 1'b1};
    vecs[1] = '{p: 9,   exp_baud: 20'd8,   exp_lock: 1'b1};
    vecs[2] = '{p: 8,   exp_baud: 20'd8,   exp_lock: 1'b0};
    vecs[3] = '{p: 25,  exp_baud: 20'd24,  exp_lock: 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nRst = 1'b1;
    idle(20);

    // Table of sync rates; a rejected rate leaves the previous divisor in place.
    for (int i = 0; i < 4; i++) begin
      e0 = err_cnt;
      fork
        send_sync(vecs[i].p);
        if (vecs[i].exp_lock) watch_lock(vecs[i].p);
        else watch_err(vecs[i].p);
      join
      check("vec_locked", locked, vecs[i].exp_lock);
      check("vec_baud", baud, vecs[i].exp_baud);
      check("vec_err_count", err_cnt - e0, vecs[i].exp_lock ? 0 : 1);
      if (vecs[i].exp_lock) begin
        check("locked_not_busy", busy, 0);
        if (i == 0) begin
          // rx traffic while locked is ignored.
          send_sync(20);
          check("locked_ignores_rx", locked, 1);
          check("locked_baud_kept", baud, vecs[i].exp_baud);
        end
        do_relock(vecs[i].exp_baud);
      end
      idle(30);
    end

    // Start bit then line stuck low: timeout counted from the start edge.
    e0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    t = 0;
    while (err !== 1'b1 && t < int'(MAXC) + 50) begin
      @(negedge clk);
      t++;
      if (t == 10) check("measure_busy", busy, 1);
    end
    check("timeout_latency", t, int'(MAXC) + 4);
    check("timeout_back_to_idle", busy, 0);
    idle(30);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_no_lock", locked, 0);

    // Short low pulse right after a start edge is rejected as a glitch.
    e0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_err_count", err_cnt - e0, 1);
    check("glitch_no_lock", locked, 0);
    idle(30);
    fork
      send_sync(40);
      watch_lock(40);
    join
    check("post_glitch_baud", baud, 39);
    do_relock(20'd39);
    idle(30);

    // relock during the ack aborts it for good.
    fork
      send_sync(30);
      begin
        wait_tx_low(600);
        repeat (130) @(negedge clk);
        check("ack_mid_tx_low", tx, 0);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        check("relock_tx_high", tx, 1);
        check("relock_unlocked", locked, 0);
        bad = 0;
        repeat (210) begin
          @(negedge clk);
          if (tx !== 1'b1 || locked !== 1'b0) bad++;
        end
        check("abort_not_resumed", bad, 0);
      end
    join
    idle(30);
    fork
      send_sync(100);
      watch_lock(100);
    join
    check("relock_new_baud", baud, 99);
    do_relock(20'd99);
    idle(30);

    // Async reset during measurement.
    fork
      send_sync(50);
      begin
        repeat (150) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        nRst = 1'b0;
        #1;
        check_reset_outputs("rst_measure");
      end
    join
    @(negedge clk);
    nRst = 1'b1;
    idle(30);
    fork
      send_sync(60);
      watch_lock(60);
    join
    check("after_rst_measure_baud", baud, 59);
    do_relock(20'd59);
    idle(30);

    // Async reset during the ack.
    fork
      send_sync(20);
      begin
        wait_tx_low(400);
        repeat (45) @(negedge clk);
        check("pre_reset_ack_tx", tx, 0);
        nRst = 1'b0;
        #1;
        check_reset_outputs("rst_ack");
      end
    join
    @(negedge clk);
    nRst = 1'b1;
    idle(30);
    fork
      send_sync(33);
      watch_lock(33);
    join
    check("after_rst_ack_baud", baud, 32);
    check("after_rst_ack_locked", locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
